// File: rtl/reg_file_sb_pkg.sv
// Shared constants and types for the decode register file.
// Holds default sizes, the zero register and the legacy pause encoding.
package reg_file_sb_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NUM_RD_DEF = 2;
    localparam int PIPE_D_DEF = 3;
    localparam int CNT_W_DEF  = 32;

    // Architectural zero register index.
    localparam int REG_ZERO = 0;

    // Old two-port pause code, kept for blocks not yet on the hazard mask.
    typedef enum logic [1:0] {
        PAUSE_NONE = 2'b00,
        PAUSE_RS1  = 2'b01,
        PAUSE_RS2  = 2'b10,
        PAUSE_BOTH = 2'b11
    } pause_e;

    // Map a two-port hazard mask onto the legacy pause code.
    function automatic pause_e pause_from_hazard(input logic [1:0] hz);
        unique case (hz)
            2'b00:   return PAUSE_NONE;
            2'b01:   return PAUSE_RS1;
            2'b10:   return PAUSE_RS2;
            default: return PAUSE_BOTH;
        endcase
    endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// Decode-side bus of the register file: reads, issue, flush, write-back.
// master drives requests, slave is the register file.
interface reg_file_sb_if
    import reg_file_sb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = NUM_RD_DEF,
    parameter int CNT_W  = CNT_W_DEF
);

    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_hazard;
    logic                     issue_valid;
    logic                     issue_we;
    logic [ADDR_W-1:0]        issue_dst;
    logic                     stall;
    logic                     flush;
    logic                     wb_we;
    logic [ADDR_W-1:0]        wb_addr;
    logic [DATA_W-1:0]        wb_data;
    logic [CNT_W-1:0]         stall_cnt;

    modport master (
        output rd_addr, issue_valid, issue_we, issue_dst,
        output flush, wb_we, wb_addr, wb_data,
        input  rd_data, rd_hazard, stall, stall_cnt
    );

    modport slave (
        input  rd_addr, issue_valid, issue_we, issue_dst,
        input  flush, wb_we, wb_addr, wb_data,
        output rd_data, rd_hazard, stall, stall_cnt
    );

endinterface

// File: rtl/reg_scoreboard.sv
// In-flight writer tracking: an age-ordered shift chain of destinations.
// A read port is hazarded while any valid entry holds its address.
module reg_scoreboard
    import reg_file_sb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = NUM_RD_DEF,
    parameter int PIPE_D = PIPE_D_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    input  logic                     issue_valid_i,
    input  logic                     issue_we_i,
    input  logic [ADDR_W-1:0]        issue_dst_i,
    input  logic                     stall_i,
    input  logic                     flush_i,
    output logic [NUM_RD-1:0]        hazard_o
);

    localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

    logic [PIPE_D-1:0] v_q;
    logic [PIPE_D-1:0] v_d;
    logic [ADDR_W-1:0] addr_q [PIPE_D];
    logic [ADDR_W-1:0] addr_d [PIPE_D];
    logic              ins;

    // Only real, accepted writers enter; stalled or flushed issues are bubbles.
    assign ins = issue_valid_i & issue_we_i & (issue_dst_i != ZERO)
               & ~stall_i & ~flush_i;

    // Next chain state: shift by one, flush drops every valid bit.
    always_comb begin
        v_d = '0;
        for (int k = 0; k < PIPE_D; k++) begin
            addr_d[k] = '0;
        end
        v_d[0]    = ins;
        addr_d[0] = ins ? issue_dst_i : '0;
        for (int k = 1; k < PIPE_D; k++) begin
            v_d[k]    = v_q[k-1] & ~flush_i;
            addr_d[k] = addr_q[k-1];
        end
    end

    // Chain registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            for (int k = 0; k < PIPE_D; k++) begin
                addr_q[k] <= '0;
            end
        end else begin
            v_q    <= v_d;
            addr_q <= addr_d;
        end
    end

    // Per-port match against every valid entry; r0 never hazards.
    always_comb begin
        hazard_o = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            for (int k = 0; k < PIPE_D; k++) begin
                if (rd_addr_i[p*ADDR_W +: ADDR_W] != ZERO && v_q[k] &&
                    addr_q[k] == rd_addr_i[p*ADDR_W +: ADDR_W]) begin
                    hazard_o[p] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// Decode register file with write-back bypass and writer scoreboard.
// Raises per-port hazards, a decode stall and a saturating stall count.
module reg_file_sb
    import reg_file_sb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = NUM_RD_DEF,
    parameter int PIPE_D = PIPE_D_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    reg_file_sb_if.slave  bus
);

    localparam int                NREG    = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO    = ADDR_W'(REG_ZERO);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] rd_w   [NUM_RD];
    logic [NUM_RD*DATA_W-1:0] rd_bus;
    logic [NUM_RD-1:0] hazard;
    logic              stall;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  stall_cnt_d;

    reg_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD),
        .PIPE_D (PIPE_D)
    ) u_sb (
        .clk           (clk),
        .rst           (rst),
        .rd_addr_i     (bus.rd_addr),
        .issue_valid_i (bus.issue_valid),
        .issue_we_i    (bus.issue_we),
        .issue_dst_i   (bus.issue_dst),
        .stall_i       (stall),
        .flush_i       (bus.flush),
        .hazard_o      (hazard)
    );

    assign stall         = bus.issue_valid & (|hazard);
    assign bus.stall     = stall;
    assign bus.rd_hazard = hazard;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.rd_data   = rd_bus;

    // Register array write; r0 writes are dropped, flush has no effect here.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (bus.wb_we && bus.wb_addr != ZERO) begin
            regs_q[bus.wb_addr] <= bus.wb_data;
        end
    end

    // Read ports: zero register, then write-first bypass, then the array.
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              byp;
        assign ra  = bus.rd_addr[p*ADDR_W +: ADDR_W];
        assign byp = bus.wb_we && (bus.wb_addr == ra);
        assign rd_w[p] = (ra == ZERO) ? '0
                       : byp          ? bus.wb_data
                       :                regs_q[ra];
    end

    // Pack the per-port read data onto the bus.
    always_comb begin
        rd_bus = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            rd_bus[p*DATA_W +: DATA_W] = rd_w[p];
        end
    end

    // Saturating stall count.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && stall_cnt_q != CNT_MAX) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: stimulus queues expected outputs,
// a negedge monitor pops and compares them.
module tb_reg_file_sb;

    typedef struct {
        string       nm;
        logic        c0;
        logic [31:0] d0;
        logic        c1;
        logic [31:0] d1;
        logic [1:0]  hz;
        logic        st;
        logic [3:0]  cnt;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   exp_cnt;
    exp_t q[$];

    reg_file_sb_if #(
        .DATA_W (32),
        .ADDR_W (5),
        .NUM_RD (2),
        .CNT_W  (4)
    ) bus ();

    reg_file_sb #(
        .DATA_W (32),
        .ADDR_W (5),
        .NUM_RD (2),
        .PIPE_D (3),
        .CNT_W  (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic cmp(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // Monitor: outputs are combinational, compare mid-cycle.
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            if (e.c0) cmp({e.nm, ".d0"}, bus.rd_data[31:0], e.d0);
            if (e.c1) cmp({e.nm, ".d1"}, bus.rd_data[63:32], e.d1);
            cmp({e.nm, ".hz"}, 32'(bus.rd_hazard), 32'(e.hz));
            cmp({e.nm, ".st"}, 32'(bus.stall), 32'(e.st));
            cmp({e.nm, ".cnt"}, 32'(bus.stall_cnt), 32'(e.cnt));
        end
    end

    task automatic idle();
        rst             = 1'b0;
        bus.rd_addr     = '0;
        bus.issue_valid = 1'b0;
        bus.issue_we    = 1'b0;
        bus.issue_dst   = '0;
        bus.flush       = 1'b0;
        bus.wb_we       = 1'b0;
        bus.wb_addr     = '0;
        bus.wb_data     = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        bus.rd_addr = {a1, a0};
    endtask

    task automatic iss(input logic we, input logic [4:0] dst);
        bus.issue_valid = 1'b1;
        bus.issue_we    = we;
        bus.issue_dst   = dst;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        bus.wb_we   = 1'b1;
        bus.wb_addr = a;
        bus.wb_data = d;
    endtask

    // Queue this cycle's expectation; the count model advances afterwards.
    task automatic chk(input string nm,
                       input logic c0, input logic [31:0] d0,
                       input logic c1, input logic [31:0] d1,
                       input logic [1:0] hz, input logic st);
        exp_t e;
        e.nm  = nm;
        e.c0  = c0;
        e.d0  = d0;
        e.c1  = c1;
        e.d1  = d1;
        e.hz  = hz;
        e.st  = st;
        e.cnt = 4'(exp_cnt);
        q.push_back(e);
        if (rst) exp_cnt = 0;
        else if (st && exp_cnt != 15) exp_cnt++;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        exp_cnt  = 0;
        idle();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        idle();

        rd(0, 7);
        chk("rst_rd", 1, 0, 1, 0, 2'b00, 0); step();
        wb(5, 32'hDEADBEEF); rd(5, 5);
        chk("byp", 1, 32'hDEADBEEF, 1, 32'hDEADBEEF, 2'b00, 0); step();
        wb(0, 32'h1234); rd(5, 0);
        chk("arr", 1, 32'hDEADBEEF, 1, 0, 2'b00, 0); step();
        rd(0, 5);
        chk("r0", 1, 0, 1, 32'hDEADBEEF, 2'b00, 0); step();
        wb(5, 32'h11111111); rd(5, 7);
        chk("byp2", 1, 32'h11111111, 1, 0, 2'b00, 0); step();

        iss(1, 3); rd(5, 0);
        chk("raw_iss", 1, 32'h11111111, 0, 0, 2'b00, 0); step();
        iss(0, 0); rd(0, 3);
        chk("raw_s1", 0, 0, 0, 0, 2'b10, 1); step();
        iss(0, 0); rd(0, 3);
        chk("raw_s2", 0, 0, 0, 0, 2'b10, 1); step();
        iss(0, 0); rd(0, 3);
        chk("raw_s3", 0, 0, 0, 0, 2'b10, 1); step();
        iss(0, 0); rd(0, 3); wb(3, 32'hCAFEF00D);
        chk("raw_rel", 0, 0, 1, 32'hCAFEF00D, 2'b00, 0); step();
        rd(0, 3);
        chk("raw_arr", 0, 0, 1, 32'hCAFEF00D, 2'b00, 0); step();

        iss(0, 3);
        chk("nowe_iss", 0, 0, 0, 0, 2'b00, 0); step();
        iss(1, 0); rd(3, 0);
        chk("nowe_rd", 0, 0, 0, 0, 2'b00, 0); step();
        iss(0, 0); rd(0, 3);
        chk("r0_rd", 0, 0, 0, 0, 2'b00, 0); step();

        iss(1, 6); rd(3, 0);
        chk("b2b_a", 0, 0, 0, 0, 2'b00, 0); step();
        iss(1, 7); rd(3, 5);
        chk("b2b_b", 0, 0, 0, 0, 2'b00, 0); step();
        rd(6, 7);
        chk("b2b_nv", 0, 0, 0, 0, 2'b11, 0); step();
        rd(6, 7);
        chk("dr1", 0, 0, 0, 0, 2'b11, 0); step();
        rd(6, 7);
        chk("dr2", 0, 0, 0, 0, 2'b10, 0); step();
        rd(6, 7);
        chk("dr3", 0, 0, 0, 0, 2'b00, 0); step();

        iss(1, 9);
        chk("fl_iss", 0, 0, 0, 0, 2'b00, 0); step();
        bus.flush = 1'b1; rd(9, 12); wb(12, 32'h12);
        chk("fl_cyc", 0, 0, 1, 32'h12, 2'b01, 0); step();
        iss(0, 0); rd(9, 12);
        chk("fl_after", 0, 0, 1, 32'h12, 2'b00, 0); step();
        bus.flush = 1'b1; iss(1, 10);
        chk("fl_iss2", 0, 0, 0, 0, 2'b00, 0); step();
        iss(0, 0); rd(0, 10);
        chk("fl_rd", 0, 0, 0, 0, 2'b00, 0); step();

        iss(1, 13);
        chk("mp_a", 0, 0, 0, 0, 2'b00, 0); step();
        iss(1, 13);
        chk("mp_b", 0, 0, 0, 0, 2'b00, 0); step();
        for (int i = 0; i < 3; i++) begin
            iss(0, 0); rd(13, 0);
            chk("mp_s", 0, 0, 0, 0, 2'b01, 1); step();
        end
        iss(0, 0); rd(13, 0);
        chk("mp_rel", 0, 0, 0, 0, 2'b00, 0); step();

        for (int e = 0; e < 4; e++) begin
            iss(1, 11);
            chk("sat_iss", 0, 0, 0, 0, 2'b00, 0); step();
            for (int i = 0; i < 3; i++) begin
                iss(0, 0); rd(11, 0);
                chk("sat_st", 0, 0, 0, 0, 2'b01, 1); step();
            end
        end

        iss(1, 11);
        chk("rst_iss", 0, 0, 0, 0, 2'b00, 0); step();
        iss(0, 0); rd(11, 0); rst = 1'b1;
        chk("rst_st", 0, 0, 0, 0, 2'b01, 1); step();
        iss(0, 0); rd(11, 5);
        chk("rst_after", 0, 0, 1, 0, 2'b00, 0); step();

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain act=%0d exp=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised general-purpose register file with an integrated write scoreboard for the in-order pipeline. It sits in decode, serves NUM_RD combinational read ports with write-back bypass, and tracks the destinations of in-flight writers. It raises per-port hazard flags and a decode stall, replacing the fixed two-port pause encoding. Only real writers are tracked, bubbles are inserted on stall, and in-flight state is cleared on flush.

## Interface
- DATA_W, 32, register width
- ADDR_W, 5, register address width; register count = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- PIPE_D, 3, cycles from issue until the writer's write-back cycle, exclusive (1..6)
- CNT_W, 32, stall-counter width
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port p occupies bits [p*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, combinational
- rd_hazard  out  NUM_RD  per-port RAW hazard flag
- issue_valid  in  1  decode holds a valid instruction
- issue_we  in  1  that instruction writes a register
- issue_dst  in  ADDR_W  its destination register
- stall  out  1  decode must hold; equals issue_valid & (|rd_hazard)
- flush  in  1  squash all in-flight writers (branch/exception)
- wb_we  in  1  write-back enable
- wb_addr  in  ADDR_W  write-back address
- wb_data  in  DATA_W  write-back data
- stall_cnt  out  CNT_W  count of stalled cycles, saturating

## Operation
- Register array: 2**ADDR_W x DATA_W. Register 0 always reads 0, and writes to it are dropped.
- Write: at the clock edge, if wb_we and wb_addr != 0, then reg[wb_addr] <= wb_data.
- Read port p, in priority order:
  - rd_addr = 0 -> 0
  - wb_we & wb_addr == rd_addr & wb_addr != 0 -> wb_data (write-first bypass)
  - otherwise -> reg[rd_addr]
- Scoreboard: a shift chain of PIPE_D entries {v, addr}, shifting every cycle (entry k <= entry k-1).
- Entry 0 loads {1, issue_dst} when issue_valid & issue_we & issue_dst != 0 & !stall & !flush. Otherwise it loads {0, 0} (bubble).
- rd_hazard[p] = (rd_addr_p != 0) & (some entry has v & addr == rd_addr_p). Entries with v = 0 never match.
- flush: every entry's v <= 0 at the edge, and the current issue is not inserted. Flush has priority over issue and stall. The register array is unaffected, and a write-back in the same cycle still commits.
- stall_cnt increments by 1 every cycle that stall = 1 and holds at its maximum 2**CNT_W - 1.
- Reset: all registers 0, all entries v = 0 / addr = 0, stall_cnt = 0. Consequently rd_data = 0, rd_hazard = 0 and stall = 0 from the cycle after reset.
- Reset takes priority over flush and over wb_we in the same cycle.

## Timing
- Read latency 0 (combinational from rd_addr, wb_*).
- A writer issued in cycle t occupies entry k during cycle t+1+k and is visible to hazard checks in cycles t+1 .. t+PIPE_D.
- Its wb_we arrives in cycle t+PIPE_D+1, where the bypass supplies it. A dependent instruction therefore stalls for at most PIPE_D cycles.
- Stall timing is independent of wb_we. Scoreboard age alone determines the stall, so hazards persist until the entry shifts out.
- The same register pending in several entries keeps the hazard asserted until the youngest of those entries retires.
- Back-to-back issue with no dependency causes no stall. A dependency on the instruction issued in the previous cycle stalls for exactly PIPE_D cycles.
- Reset asserted mid-stall clears the stall on the next cycle.

## Structure
- A shared package holds the default DATA_W, ADDR_W, PIPE_D and the REG_ZERO constant. The per-port hazard bitmask supersedes the PAUSE_* encoding, which stays in the package only for legacy users.
- One sub-module: reg_scoreboard, which contains the shift chain, flush and match logic and outputs the per-port hazard vector.
- The array, the bypass muxes and stall_cnt live in reg_file_sb.

## Test plan
- Reset, then read ports 0/1 at addresses 0 and 7 -> rd_data = 0 and 0, rd_hazard = 00, stall = 0, stall_cnt = 0.
- wb_we, addr 5, data 0xDEADBEEF, with port 0 reading 5 in the same cycle -> rd_data0 = 0xDEADBEEF via bypass. The following cycle reads the same value from the array. A write to address 0 with 0x1234 -> address 0 still reads 0.
- Issue writer to r3 at t = 0, then from t = 1 a dependent instruction reading r3 on port 1 -> stall = 1 for cycles 1..3, released at cycle 4 together with wb_we r3 and the bypassed data. stall_cnt = 3.
- Issue with issue_we = 0 to r3, or issue_we = 1 to r0, then read r3/r0 -> no hazard and no stall.
- Writer to r9 issued, flush asserted the next cycle, reader of r9 afterwards -> rd_hazard = 0 from the cycle after the flush edge. Flush asserted together with an issue -> that issue is not tracked.
- Hold a hazard with CNT_W = 4 for 20 cycles -> stall_cnt saturates at 15. Then assert rst while the stall is active -> stall = 0 and stall_cnt = 0 on the next cycle.
